// File: rtl/bit_mux_pkg.sv
// Shared constants and helpers for the bit-select mux tree.
package bit_mux_pkg;

  localparam int unsigned LEAF_WIDTH = 8;
  localparam int unsigned ROOT_FANIN = 4;

  // Number of 8:1 leaves needed to cover a data word of the given width.
  function automatic int unsigned num_leaves(input int unsigned width);
    return width / LEAF_WIDTH;
  endfunction

endpackage

// File: rtl/mux4to1.sv
// Combinational 4:1 single-bit mux; building block for leaves and root.
module mux4to1 (
  input  logic [3:0] in,
  input  logic [1:0] sel,
  output logic       out
);

  always_comb begin
    out = 1'b0;
    case (sel)
      2'd0:    out = in[0];
      2'd1:    out = in[1];
      2'd2:    out = in[2];
      default: out = in[3];
    endcase
  end

endmodule

// File: rtl/bit_select_mux.sv
// Selects in_data[sel] through an 8:1 leaf / 4:1 root mux tree, with a
// registered copy and valid flag for pipelined read paths.
module bit_select_mux
  import bit_mux_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] sel,
  input  logic                     in_valid,
  output logic                     out_comb,
  output logic                     out_q,
  output logic                     out_valid
);

  localparam int unsigned SEL_W  = $clog2(WIDTH);
  localparam int unsigned NLEAF  = num_leaves(WIDTH);
  localparam int unsigned ROOT_W = SEL_W - 3;
  localparam int unsigned NLV    = (ROOT_W + 1) / 2;

  logic [NLEAF-1:0] leaf_y;

  // Each 8:1 leaf is two 4:1 halves joined on sel[2].
  for (genvar k = 0; k < NLEAF; k++) begin : g_leaf
    logic lo_y;
    logic hi_y;

    mux4to1 u_lo (
      .in  (in_data[LEAF_WIDTH*k +: 4]),
      .sel (sel[1:0]),
      .out (lo_y)
    );

    mux4to1 u_hi (
      .in  (in_data[LEAF_WIDTH*k + 4 +: 4]),
      .sel (sel[1:0]),
      .out (hi_y)
    );

    assign leaf_y[k] = sel[2] ? hi_y : lo_y;
  end

  // Root: 4:1 levels on successive sel bit pairs, 2:1 last level if one bit is left.
  if (NLV == 0) begin : g_no_root
    assign out_comb = leaf_y[0];
  end else begin : g_root
    for (genvar l = 0; l < NLV; l++) begin : g_lvl
      localparam int unsigned BITS = ((ROOT_W - 2*l) >= 2) ? 2 : 1;
      localparam int unsigned NIN  = NLEAF >> (2*l);
      localparam int unsigned NOUT = NIN >> BITS;

      logic [NIN-1:0]  x;
      logic [NOUT-1:0] y;

      if (l == 0) begin : g_src_leaf
        assign x = leaf_y;
      end else begin : g_src_lvl
        assign x = g_lvl[l-1].y;
      end

      for (genvar j = 0; j < NOUT; j++) begin : g_node
        if (BITS == 2) begin : g_m4
          mux4to1 u_m4 (
            .in  (x[ROOT_FANIN*j +: ROOT_FANIN]),
            .sel (sel[3 + 2*l +: 2]),
            .out (y[j])
          );
        end else begin : g_m2
          assign y[j] = sel[3 + 2*l] ? x[2*j + 1] : x[2*j];
        end
      end
    end

    assign out_comb = g_lvl[NLV-1].y[0];
  end

  // Capture register; in_valid=0 keeps the last bit but drops valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q     <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      out_q     <= out_comb;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bit_select_mux.sv
// Self-checking bench for bit_select_mux (WIDTH=32): directed sweeps plus
// randomized traffic against a shift-and-mask reference model.
module tb_bit_select_mux;

  localparam int unsigned WIDTH = 32;

  logic              clk;
  logic              reset;
  logic [WIDTH-1:0]  in_data;
  logic [4:0]        sel;
  logic              in_valid;
  logic              out_comb;
  logic              out_q;
  logic              out_valid;

  int unsigned total;
  int unsigned bad;

  bit_select_mux #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .sel       (sel),
    .in_valid  (in_valid),
    .out_comb  (out_comb),
    .out_q     (out_q),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_bit(input logic [31:0] d, input int unsigned s);
    logic [31:0] t;
    t = (d >> s) & 32'd1;
    return t[0];
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    logic        exp_q;
    logic        exp_v;
    logic [36:0] word;

    total    = 0;
    bad      = 0;
    reset    = 1'b0;
    in_data  = '0;
    sel      = '0;
    in_valid = 1'b0;

    // Reset takes effect before any clock edge (first posedge at t=5).
    #1 reset = 1'b1;
    #1;
    check("reset_q_noclk", out_q, 1'b0);
    check("reset_v_noclk", out_valid, 1'b0);

    // Exhaustive {in_data,sel} = i sweep.
    for (int i = 0; i < 1024; i++) begin
      word    = 37'(i);
      in_data = word[36:5];
      sel     = word[4:0];
      #1;
      check($sformatf("sweep_%0d", i), out_comb, model_bit(in_data, sel));
      #9;
    end
    check("sweep_reset_q", out_q, 1'b0);

    in_data = 32'h8000_0000;
    sel     = 5'd31;
    #1 check("msb_sel31", out_comb, 1'b1);
    sel = 5'd30;
    #1 check("msb_sel30", out_comb, 1'b0);
    in_data = 32'h0000_0001;
    sel     = 5'd0;
    #1 check("lsb_sel0", out_comb, 1'b1);

    // Walking one: only sel==k selects a 1.
    for (int k = 0; k < 32; k++) begin
      for (int s = 0; s < 32; s++) begin
        in_data = 32'd1 << k;
        sel     = 5'(s);
        #1;
        check($sformatf("walk_k%0d_s%0d", k, s), out_comb, (s == k) ? 1'b1 : 1'b0);
        #1;
      end
    end

    // Registered path: first capture after reset release.
    @(negedge clk);
    reset    = 1'b0;
    in_data  = 32'hA5A5_A5A5;
    sel      = 5'd5;
    in_valid = 1'b1;
    @(posedge clk); #1;
    check("cap_q", out_q, 1'b1);
    check("cap_v", out_valid, 1'b1);

    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 32'h0;
    @(posedge clk); #1;
    check("hold_q", out_q, 1'b1);
    check("hold_v", out_valid, 1'b0);

    // Reset between edges drops both outputs immediately.
    @(negedge clk);
    in_data  = 32'hA5A5_A5A5;
    sel      = 5'd5;
    in_valid = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_q", out_q, 1'b1);
    check("pre_rst_v", out_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_q", out_q, 1'b0);
    check("mid_rst_v", out_valid, 1'b0);
    check("mid_rst_comb5", out_comb, 1'b1);
    sel = 5'd1;
    #1 check("mid_rst_comb1", out_comb, 1'b0);
    @(posedge clk); #1;
    check("rst_discard_q", out_q, 1'b0);
    check("rst_discard_v", out_valid, 1'b0);

    // Randomized traffic with occasional async reset.
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    exp_q    = 1'b0;
    exp_v    = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      in_data  = $urandom;
      sel      = 5'($urandom_range(0, 31));
      in_valid = 1'($urandom_range(0, 1));
      reset    = ($urandom_range(0, 15) == 0);
      #1;
      check($sformatf("rnd_comb_%0d", n), out_comb, model_bit(in_data, sel));
      if (reset) begin
        exp_q = 1'b0;
        exp_v = 1'b0;
        check($sformatf("rnd_async_q_%0d", n), out_q, 1'b0);
      end
      @(posedge clk);
      if (reset) begin
        exp_q = 1'b0;
        exp_v = 1'b0;
      end else if (in_valid) begin
        exp_q = model_bit(in_data, sel);
        exp_v = 1'b1;
      end else begin
        exp_v = 1'b0;
      end
      #1;
      check($sformatf("rnd_q_%0d", n), out_q, exp_q);
      check($sformatf("rnd_v_%0d", n), out_valid, exp_v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
